// File: rtl/adc_spi_if.sv
// Serial configuration link between a config master and the ADC-style responder.
// Strict direction: the master owns sclk/sdenb/sdio, the responder owns sdi/sdi_oe.
interface adc_spi_if;
  logic sclk;
  logic sdenb;
  logic sdio;
  logic sdi;
  logic sdi_oe;

  modport master (output sclk, output sdenb, output sdio, input sdi, input sdi_oe);
  modport slave  (input sclk, input sdenb, input sdio, output sdi, output sdi_oe);
endinterface

// File: rtl/adc_spi_responder.sv
// Target end of the 24-bit ADC configuration link with an on-board register file.
// Frame (MSB first): [23] R/W, [22:16] address, [15:0] data.
module adc_spi_responder #(
  parameter int REG_DEPTH = 64
) (
  input  logic        clk,
  input  logic        resetb,
  adc_spi_if.slave    bus,
  input  logic        sresetb,
  output logic        wr_stb,
  output logic [6:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic [7:0]  frame_err_cnt,
  output logic [1:0]  fsm_state
);

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [7:0] DEPTH8 = 8'(REG_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t      state;
  logic [1:0]  sclk_q, sdenb_q, sdio_q, srst_q;
  logic        sclk_d;
  logic [4:0]  bit_cnt;
  logic [14:0] shreg;
  logic        rw;
  logic [6:0]  addr;
  logic [15:0] rd_sh;
  logic [15:0] regs [REG_DEPTH];

  logic        sclk_rise, sclk_fall, en_n, sdio_s, srst_n;
  logic [6:0]  hdr_addr;
  logic        hdr_ok, addr_ok, commit_now;
  logic [15:0] rd_word, data_word;

  // Two-flop synchronisers; sdenb and sresetb idle high so nothing fires out of reset.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sclk_q  <= 2'b00;
      sdenb_q <= 2'b11;
      sdio_q  <= 2'b00;
      srst_q  <= 2'b11;
      sclk_d  <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[0], bus.sclk};
      sdenb_q <= {sdenb_q[0], bus.sdenb};
      sdio_q  <= {sdio_q[0], bus.sdio};
      srst_q  <= {srst_q[0], sresetb};
      sclk_d  <= sclk_q[1];
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[1] & sclk_d;
  assign en_n      = sdenb_q[1];
  assign sdio_s    = sdio_q[1];
  assign srst_n    = srst_q[1];
  assign busy      = ~sdenb_q[1];
  assign fsm_state = state;

  // After seven header bits the eighth arrives on sdio_s, completing the address.
  assign hdr_addr  = {shreg[5:0], sdio_s};
  assign hdr_ok    = {1'b0, hdr_addr} < DEPTH8;
  assign rd_word   = hdr_ok ? regs[hdr_addr[AW-1:0]] : 16'h0000;
  assign addr_ok   = {1'b0, addr} < DEPTH8;
  assign data_word = {shreg[14:0], sdio_s};
  assign commit_now = (state == DATA) && !en_n && sclk_rise && (bit_cnt == 5'd23) &&
                      !rw && addr_ok && srst_n;

  // Soft reset clears every clk it is held, and wins over a same-clk commit.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 16'h0000;
    end else if (!srst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= 16'h0000;
    end else if (commit_now) begin
      regs[addr[AW-1:0]] <= data_word;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state         <= IDLE;
      bit_cnt       <= 5'd0;
      shreg         <= 15'd0;
      rw            <= 1'b0;
      addr          <= 7'd0;
      rd_sh         <= 16'h0000;
      bus.sdi       <= 1'b0;
      bus.sdi_oe    <= 1'b0;
      wr_stb        <= 1'b0;
      wr_addr       <= 7'd0;
      wr_data       <= 16'h0000;
      frame_err_cnt <= 8'd0;
    end else begin
      wr_stb <= 1'b0;
      case (state)
        IDLE: begin
          bus.sdi    <= 1'b0;
          bus.sdi_oe <= 1'b0;
          if (!en_n) begin
            state   <= HDR;
            bit_cnt <= 5'd0;
            shreg   <= 15'd0;
          end
        end
        HDR: begin
          bus.sdi    <= 1'b0;
          bus.sdi_oe <= 1'b0;
          if (en_n) begin
            state <= IDLE;
            if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
          end else if (sclk_rise) begin
            shreg   <= {shreg[13:0], sdio_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd7) begin
              rw    <= shreg[6];
              addr  <= hdr_addr;
              rd_sh <= rd_word;
              state <= DATA;
            end
          end
        end
        DATA: begin
          // sdenb wins over a coincident sclk rise, so a 24th rise seen together with release aborts.
          if (en_n) begin
            state      <= IDLE;
            bus.sdi    <= 1'b0;
            bus.sdi_oe <= 1'b0;
            if (frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 8'd1;
          end else if (sclk_rise) begin
            shreg   <= {shreg[13:0], sdio_s};
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd23) begin
              state <= DONE;
              if (commit_now) begin
                wr_stb  <= 1'b1;
                wr_addr <= addr;
                wr_data <= data_word;
              end
            end
          end else if (sclk_fall && rw) begin
            bus.sdi    <= rd_sh[15];
            bus.sdi_oe <= 1'b1;
            rd_sh      <= {rd_sh[14:0], 1'b0};
          end
        end
        DONE: begin
          if (en_n) begin
            state      <= IDLE;
            bus.sdi    <= 1'b0;
            bus.sdi_oe <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: a master-side driver plus a register-file model of the target.
module tb_adc_spi_responder;
  logic        clk = 1'b0;
  logic        resetb;
  logic        sresetb;
  logic        wr_stb;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic [7:0]  frame_err_cnt;
  logic [1:0]  fsm_state;

  adc_spi_if bus ();

  adc_spi_responder #(.REG_DEPTH(64)) dut (
    .clk(clk), .resetb(resetb), .bus(bus.slave), .sresetb(sresetb),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_err_cnt(frame_err_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [15:0] mem [128];
  int          exp_err = 0;
  logic [22:0] exp_q[$];
  bit          rd_ok = 1'b0;
  bit          quiet = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: sclk period of 8 clk, sdio set on the fall, sdi captured just before each rise
  task automatic run_frame(input logic [23:0] f, input int nbits, input bit release_en,
                           output logic [15:0] cap);
    quiet = 1'b0;
    rd_ok = f[23];
    cap = 16'h0000;
    bus.sdenb = 1'b0;
    tick(8);
    for (int i = 0; i < nbits; i++) begin
      bus.sclk = 1'b0;
      bus.sdio = f[23-i];
      tick(4);
      if (i >= 8) cap = {cap[14:0], bus.sdi};
      bus.sclk = 1'b1;
      tick(4);
    end
    bus.sclk = 1'b0;
    if (release_en) begin
      tick(4);
      bus.sdenb = 1'b1;
      tick(8);
      rd_ok = 1'b0;
      quiet = 1'b1;
    end
  endtask

  // model-level frame: decides what the target must do, then drives it
  task automatic do_frame(input logic [23:0] f, input int nbits, output logic [15:0] cap);
    logic [6:0]  a;
    logic [15:0] exp_rd;
    a = f[22:16];
    exp_rd = (a < 7'd64) ? mem[a] : 16'h0000;
    if (nbits < 24) begin
      exp_err = (exp_err == 255) ? 255 : exp_err + 1;
    end else if (!f[23] && a < 7'd64) begin
      mem[a] = f[15:0];
      exp_q.push_back({a, f[15:0]});
    end
    run_frame(f, nbits, 1'b1, cap);
    if (nbits == 24 && f[23]) check($sformatf("read_%02h", a), {16'h0, cap}, {16'h0, exp_rd});
    check("wr_stb_pending", exp_q.size(), 0);
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    if (resetb) begin
      if (wr_stb) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wr_stb_unexpected: got addr %0h data %0h expected no strobe", wr_addr, wr_data);
        end else begin
          logic [22:0] e;
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            errors++;
            $display("FAIL wr_stb_payload: got %0h expected %0h", {wr_addr, wr_data}, e);
          end
        end
      end
      if (!rd_ok) begin
        checks++;
        if (bus.sdi_oe !== 1'b0 || bus.sdi !== 1'b0) begin
          errors++;
          $display("FAIL sdi_idle: got oe=%b sdi=%b expected 0/0", bus.sdi_oe, bus.sdi);
        end
      end
      if (quiet) begin
        checks++;
        if (frame_err_cnt !== 8'(exp_err) || busy !== 1'b0) begin
          errors++;
          $display("FAIL quiet_state: got err=%0d busy=%b expected err=%0d busy=0",
                   frame_err_cnt, busy, exp_err);
        end
      end
    end
  end

  initial begin
    #800us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cap;
    logic [23:0] f;
    logic [6:0]  a;
    int          kind;
    logic [6:0]  waddr [15];

    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    resetb = 1'b0;
    sresetb = 1'b1;
    bus.sclk = 1'b0;
    bus.sdenb = 1'b1;
    bus.sdio = 1'b0;
    tick(4);
    check("rst_wr_stb", {31'h0, wr_stb}, 0);
    check("rst_wr_addr", {25'h0, wr_addr}, 0);
    check("rst_wr_data", {16'h0, wr_data}, 0);
    check("rst_sdi", {30'h0, bus.sdi_oe, bus.sdi}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_err", {24'h0, frame_err_cnt}, 0);
    check("rst_state", {30'h0, fsm_state}, 0);
    resetb = 1'b1;
    tick(4);
    quiet = 1'b1;

    // directed write then read-back
    do_frame(24'h0A1234, 24, cap);
    check("mem_0a_model", {16'h0, mem[10]}, 32'h1234);
    do_frame(24'h8A0000, 24, cap);
    check("read_0a_literal", {16'h0, cap}, 32'h1234);

    // abort after 13 bits of a write to addr 5
    do_frame(24'h05ABCD, 13, cap);
    check("err_after_abort", {24'h0, frame_err_cnt}, 1);
    do_frame(24'h850000, 24, cap);
    check("reg5_unchanged", {16'h0, cap}, 0);
    do_frame(24'h055AA5, 24, cap);
    do_frame(24'h850000, 24, cap);
    check("reg5_after_abort", {16'h0, cap}, 32'h5AA5);

    // out-of-range address
    do_frame(24'h50BEEF, 24, cap);
    do_frame(24'hD00000, 24, cap);
    check("oor_read", {16'h0, cap}, 0);
    check("oor_err", {24'h0, frame_err_cnt}, 1);

    // loopback: 15 random registers written then read back
    for (int i = 0; i < 15; i++) begin
      waddr[i] = 7'(i * 4 + $urandom_range(0, 3));
      do_frame({1'b0, waddr[i], 16'($urandom)}, 24, cap);
    end
    for (int i = 0; i < 15; i++) do_frame({1'b1, waddr[i], 16'h0}, 24, cap);

    // random mix of writes, reads (any address) and aborts
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      a = 7'($urandom_range(0, 127));
      f = {kind == 1, a, 16'($urandom)};
      do_frame(f, (kind == 3) ? $urandom_range(0, 23) : 24, cap);
    end

    // many aborts saturate the error counter
    for (int i = 0; i < 300; i++) do_frame(24'($urandom), $urandom_range(0, 3), cap);
    check("err_saturated", {24'h0, frame_err_cnt}, 255);

    // soft reset clears the register file
    sresetb = 1'b0;
    tick(4);
    sresetb = 1'b1;
    tick(4);
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 15; i++) do_frame({1'b1, waddr[i], 16'h0}, 24, cap);
    do_frame(24'h8A0000, 24, cap);
    check("sreset_read_0a", {16'h0, cap}, 0);
    check("sreset_keeps_err", {24'h0, frame_err_cnt}, 255);

    // hard reset mid-frame
    do_frame(24'h0C7777, 24, cap);
    run_frame(24'h0C9999, 10, 1'b0, cap);
    resetb = 1'b0;
    tick(2);
    check("midrst_wr_stb", {31'h0, wr_stb}, 0);
    check("midrst_sdi", {30'h0, bus.sdi_oe, bus.sdi}, 0);
    check("midrst_busy", {31'h0, busy}, 0);
    check("midrst_err", {24'h0, frame_err_cnt}, 0);
    check("midrst_wr", {9'h0, wr_addr, wr_data}, 0);
    check("midrst_state", {30'h0, fsm_state}, 0);
    bus.sdenb = 1'b1;
    bus.sclk = 1'b0;
    tick(3);
    resetb = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    exp_err = 0;
    rd_ok = 1'b0;
    tick(8);
    quiet = 1'b1;
    do_frame(24'h8C0000, 24, cap);
    check("midrst_reg_cleared", {16'h0, cap}, 0);
    do_frame(24'h0C4321, 24, cap);
    do_frame(24'h8C0000, 24, cap);
    check("post_rst_read", {16'h0, cap}, 32'h4321);
    check("post_rst_err", {24'h0, frame_err_cnt}, 0);

    tick(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
